// File: rtl/arm_pipelined_hazard_sequencer_if.sv
// Hazard-unit signal bundle between the ARM 5-stage datapath and its hazard sequencer.
// The datapath side uses the master modport; the hazard sequencer uses the slave modport.
interface arm_pipelined_hazard_sequencer_if;
  logic [3:0] i_RA1_Decode;
  logic [3:0] i_RA2_Decode;
  logic [3:0] i_RA1_Execute;
  logic [3:0] i_RA2_Execute;
  logic [3:0] i_WA_Execute;
  logic [3:0] i_WA_Memory;
  logic [3:0] i_WA_Writeback;
  logic       i_RegWrite_Memory;
  logic       i_RegWrite_Writeback;
  logic       i_MemToReg_Execute;
  logic       i_PCSrc_Decode;
  logic       i_PCSrc_Execute;
  logic       i_PCSrc_Memory;
  logic       i_PCSrc_Writeback;
  logic       i_BranchTaken_Execute;
  logic       i_MultiCycle_Execute;

  logic [1:0] o_ForwardA_Execute;
  logic [1:0] o_ForwardB_Execute;
  logic       o_Stall_Fetch;
  logic       o_Stall_Decode;
  logic       o_Stall_Execute;
  logic       o_Flush_Decode;
  logic       o_Flush_Execute;
  logic       o_Flush_Memory;
  logic       o_FlagHold_Execute;
  logic       o_Busy;

  modport master (
    output i_RA1_Decode, i_RA2_Decode, i_RA1_Execute, i_RA2_Execute,
           i_WA_Execute, i_WA_Memory, i_WA_Writeback,
           i_RegWrite_Memory, i_RegWrite_Writeback, i_MemToReg_Execute,
           i_PCSrc_Decode, i_PCSrc_Execute, i_PCSrc_Memory, i_PCSrc_Writeback,
           i_BranchTaken_Execute, i_MultiCycle_Execute,
    input  o_ForwardA_Execute, o_ForwardB_Execute,
           o_Stall_Fetch, o_Stall_Decode, o_Stall_Execute,
           o_Flush_Decode, o_Flush_Execute, o_Flush_Memory,
           o_FlagHold_Execute, o_Busy
  );

  modport slave (
    input  i_RA1_Decode, i_RA2_Decode, i_RA1_Execute, i_RA2_Execute,
           i_WA_Execute, i_WA_Memory, i_WA_Writeback,
           i_RegWrite_Memory, i_RegWrite_Writeback, i_MemToReg_Execute,
           i_PCSrc_Decode, i_PCSrc_Execute, i_PCSrc_Memory, i_PCSrc_Writeback,
           i_BranchTaken_Execute, i_MultiCycle_Execute,
    output o_ForwardA_Execute, o_ForwardB_Execute,
           o_Stall_Fetch, o_Stall_Decode, o_Stall_Execute,
           o_Flush_Decode, o_Flush_Execute, o_Flush_Memory,
           o_FlagHold_Execute, o_Busy
  );
endinterface

// File: rtl/arm_pipelined_hazard_sequencer.sv
// Hazard controller for the 5-stage ARM core: Execute forwarding, load-use / PC-write
// stall and flush, and sequencing of multi-cycle Execute ops with flag-write hold.
module arm_pipelined_hazard_sequencer #(
  parameter int MC_LATENCY = 4
) (
  input logic                            i_CLK,
  input logic                            i_NRESET,
  arm_pipelined_hazard_sequencer_if.slave hz
);

  localparam int CW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           mc_start;
  logic           mc_stall;
  logic           ldr_stall;
  logic           pc_pend;
  logic           flush_d;
  logic           flush_e;

  assign mc_start = (state == S_IDLE) && hz.i_MultiCycle_Execute && (MC_LATENCY > 1);
  assign mc_stall = mc_start || ((state == S_BUSY) && (cnt != '0));

  // cnt counts the remaining stalled cycles after the first; the op commits when it hits 0.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mc_start) begin
            state <= S_BUSY;
            cnt   <= CW'(MC_LATENCY - 2);
          end
        end
        S_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ldr_stall = hz.i_MemToReg_Execute &&
                     ((hz.i_RA1_Decode == hz.i_WA_Execute) ||
                      (hz.i_RA2_Decode == hz.i_WA_Execute));
  assign pc_pend   = hz.i_PCSrc_Decode || hz.i_PCSrc_Execute || hz.i_PCSrc_Memory;
  assign flush_d   = pc_pend || hz.i_PCSrc_Writeback || hz.i_BranchTaken_Execute;
  assign flush_e   = (ldr_stall || hz.i_BranchTaken_Execute) && !mc_stall;

  // A flush wins over a stall on the same pipeline register; all outputs idle in reset.
  always_comb begin
    hz.o_ForwardA_Execute = 2'b00;
    hz.o_ForwardB_Execute = 2'b00;
    hz.o_Stall_Fetch      = 1'b0;
    hz.o_Stall_Decode     = 1'b0;
    hz.o_Stall_Execute    = 1'b0;
    hz.o_Flush_Decode     = 1'b0;
    hz.o_Flush_Execute    = 1'b0;
    hz.o_Flush_Memory     = 1'b0;
    hz.o_FlagHold_Execute = 1'b0;
    hz.o_Busy             = 1'b0;
    if (i_NRESET) begin
      if (hz.i_RegWrite_Memory && (hz.i_RA1_Execute == hz.i_WA_Memory)) begin
        hz.o_ForwardA_Execute = 2'b10;
      end else if (hz.i_RegWrite_Writeback && (hz.i_RA1_Execute == hz.i_WA_Writeback)) begin
        hz.o_ForwardA_Execute = 2'b01;
      end
      if (hz.i_RegWrite_Memory && (hz.i_RA2_Execute == hz.i_WA_Memory)) begin
        hz.o_ForwardB_Execute = 2'b10;
      end else if (hz.i_RegWrite_Writeback && (hz.i_RA2_Execute == hz.i_WA_Writeback)) begin
        hz.o_ForwardB_Execute = 2'b01;
      end
      hz.o_Stall_Fetch      = ldr_stall || pc_pend || mc_stall;
      hz.o_Stall_Decode     = (ldr_stall || mc_stall) && !flush_d;
      hz.o_Stall_Execute    = mc_stall && !flush_e;
      hz.o_Flush_Decode     = flush_d;
      hz.o_Flush_Execute    = flush_e;
      hz.o_Flush_Memory     = mc_stall;
      hz.o_FlagHold_Execute = mc_stall;
      hz.o_Busy             = (state == S_BUSY);
    end
  end

endmodule
